// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazards and branch flushes, downstream hold, and saturating bubble counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,

  input  logic             flush,
  input  logic             ex_hold,

  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,

  output logic             stall_upstream,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic load_bubble;
  logic capture;
  logic stall_sat;
  logic flush_sat;

  // x0 is hardwired, so a load targeting it can never create a hazard.
  assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                    && (rs1_hit || rs2_hit);

  assign stall_upstream = (load_use || ex_hold) && !flush && !rst;

  // Flush beats hold; hold beats a load-use bubble.
  assign load_bubble = flush || (!ex_hold && load_use);
  assign capture     = !flush && !ex_hold && !load_use;

  assign stall_sat = &stall_cnt;
  assign flush_sat = &flush_cnt;

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= 3'b000;
      ex_funct7b5   <= 1'b0;
    end else if (capture) begin
      ex_valid      <= id_valid;
      ex_alu_op     <= id_alu_op;
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7b5   <= id_funct7b5;
    end
  end

  // A flush that coincides with a load-use hazard is charged to flush_cnt only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (!flush_sat) flush_cnt <= flush_cnt + 1'b1;
    end else if (!ex_hold && load_use) begin
      if (!stall_sat) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: hazard bubbles, flush priority, hold,
// counter saturation and reset.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic        id_branch, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        flush, ex_hold;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        stall_upstream;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .stall_upstream(stall_upstream), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_alu_op = 0; id_branch = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_alu_src = 0; id_reg_write = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_funct3 = 0; id_funct7b5 = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clear_id();
    id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1;
    id_rs1 = 5'd2; id_rs1_used = 1; id_imm = 32'd4; id_funct3 = 3'd2; id_rd = rd;
  endtask

  initial begin
    rst = 1; flush = 0; ex_hold = 1;
    clear_id();
    id_valid = 1; id_mem_read = 1; id_rd = 5'd4;
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_stall_up", stall_upstream, 0);
    rst = 0; ex_hold = 0;

    // R-type advances with one cycle latency
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_reg_write = 1; id_rd = 5'd5;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_data = 32'h11; id_pc = 32'h100; id_funct7b5 = 1;
    tick();
    chk("rt_ex_valid", ex_valid, 1);
    chk("rt_ex_alu_op", ex_alu_op, 2'b10);
    chk("rt_ex_rd", ex_rd, 5);
    chk("rt_ex_reg_write", ex_reg_write, 1);
    chk("rt_ex_rs1_data", ex_rs1_data, 32'h11);
    chk("rt_ex_pc", ex_pc, 32'h100);
    chk("rt_ex_f7b5", ex_funct7b5, 1);

    // load rd=3 followed by dependent add
    drive_load(5'd3);
    tick();
    chk("ld_ex_mem_read", ex_mem_read, 1);
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_reg_write = 1; id_rs1 = 5'd3; id_rs1_used = 1;
    id_rs2 = 5'd4; id_rs2_used = 1; id_rd = 5'd6;
    #1;
    chk("lu_stall_up", stall_upstream, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_mem_read", ex_mem_read, 0);
    chk("lu_bubble_reg_write", ex_reg_write, 0);
    chk("lu_bubble_rd", ex_rd, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_up_released", stall_upstream, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 6);
    chk("lu_add_alu_op", ex_alu_op, 2'b10);
    chk("lu_stall_cnt_hold", stall_cnt, 1);

    // load into x0 never stalls
    drive_load(5'd0);
    tick();
    clear_id();
    id_valid = 1; id_rs1 = 5'd0; id_rs1_used = 1; id_rd = 5'd8; id_reg_write = 1;
    #1;
    chk("x0_stall_up", stall_upstream, 0);
    tick();
    chk("x0_ex_rd", ex_rd, 8);
    chk("x0_stall_cnt", stall_cnt, 1);

    // rs2 matches but is unused
    drive_load(5'd7);
    tick();
    clear_id();
    id_valid = 1; id_alu_src = 1; id_rs1 = 5'd1; id_rs1_used = 1; id_rs2 = 5'd7;
    id_rs2_used = 0; id_rd = 5'd9; id_reg_write = 1;
    #1;
    chk("unused_stall_up", stall_upstream, 0);
    tick();
    chk("unused_ex_rd", ex_rd, 9);
    chk("unused_stall_cnt", stall_cnt, 1);

    // flush with load-use and hold
    drive_load(5'd10);
    tick();
    clear_id();
    id_valid = 1; id_rs2 = 5'd10; id_rs2_used = 1; id_rd = 5'd11; id_reg_write = 1;
    ex_hold = 1;
    #1;
    chk("hold_lu_stall_up", stall_upstream, 1);
    flush = 1;
    #1;
    chk("fl_stall_up", stall_upstream, 0);
    tick();
    chk("fl_ex_valid", ex_valid, 0);
    chk("fl_ex_mem_read", ex_mem_read, 0);
    chk("fl_ex_rd", ex_rd, 0);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 1);
    flush = 0; ex_hold = 0;

    // hold for 3 cycles
    clear_id();
    id_valid = 1; id_alu_op = 2'b01; id_branch = 1; id_rd = 5'd12; id_imm = 32'hdead;
    tick();
    chk("hd_load_rd", ex_rd, 12);
    ex_hold = 1;
    clear_id();
    id_valid = 1; id_rd = 5'd13; id_imm = 32'h1234; id_mem_write = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hd_ex_rd", ex_rd, 12);
      chk("hd_ex_imm", ex_imm, 32'hdead);
      chk("hd_ex_branch", ex_branch, 1);
      chk("hd_ex_mem_write", ex_mem_write, 0);
    end
    chk("hd_stall_up", stall_upstream, 1);
    chk("hd_stall_cnt", stall_cnt, 1);
    chk("hd_flush_cnt", flush_cnt, 1);

    // 65538 flushes while holding: counter saturates at 16'hffff
    flush = 1;
    for (int i = 0; i < 65533; i++) tick();
    chk("sat_flush_cnt_pre", flush_cnt, 16'hfffe);
    tick();
    chk("sat_flush_cnt_hit", flush_cnt, 16'hffff);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_flush_cnt", flush_cnt, 16'hffff);
    chk("sat_ex_valid", ex_valid, 0);
    chk("sat_stall_cnt", stall_cnt, 1);

    // reset mid-hold
    flush = 0;
    clear_id();
    id_valid = 1; id_rd = 5'd14; id_imm = 32'h55; id_reg_write = 1;
    tick();
    chk("pre_rst_ex_rd", ex_rd, 0);
    rst = 1;
    #1;
    chk("rst_hold_stall_up", stall_upstream, 0);
    tick();
    chk("rst2_ex_valid", ex_valid, 0);
    chk("rst2_ex_rd", ex_rd, 0);
    chk("rst2_ex_imm", ex_imm, 0);
    chk("rst2_ex_reg_write", ex_reg_write, 0);
    chk("rst2_flush_cnt", flush_cnt, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_stall_up", stall_upstream, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
